step_scheduler: RTL

- Sequences game-state updates against the VGA raster.
- Counts frames and issues one step request to the game-logic update engine every FRAMES_PER_STEP frames, only at vertical-blank start.
- Arbitrates the snake body/entity memory between the renderer (pixel lookup) and the update engine.
- Latches a filtered joystick direction for each step.
- Sits between joystick_input, the VGA controller's current-Y output and game_logic.

---
 rtl/step_scheduler_pkg.sv | 25 ++
 rtl/step_scheduler_frame_tick_gen.sv | 50 +++++
 rtl/step_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/step_scheduler_pkg.sv
// Shared encodings for the step scheduler: joystick directions, FSM states
// and the default first vertical-blank line.
package step_scheduler_pkg;

    localparam logic [1:0] DIR_UP      = 2'b00;
    localparam logic [1:0] DIR_RIGHT   = 2'b01;
    localparam logic [1:0] DIR_DOWN    = 2'b10;
    localparam logic [1:0] DIR_LEFT    = 2'b11;
    localparam logic [1:0] DIR_REVERSE = 2'b10;

    localparam int unsigned V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RELEASE   = 2'd3
    } state_t;

    // Opposite directions differ only in the upper encoding bit.
    function automatic logic is_reversal(input logic [1:0] cand, input logic [1:0] cur);
        return cand == (cur ^ DIR_REVERSE);
    endfunction

endpackage

// File: rtl/step_scheduler_frame_tick_gen.sv
// Frame pacing: registered vblank, frame_tick on vblank entry, frame counter
// with a period that is re-sampled at each wrap, and the step_due strobe.
module frame_tick_gen
    import step_scheduler_pkg::*;
#(
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter logic [7:0]  RESET_PERIOD = 8'd8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_frame_y,
    input  logic [7:0] i_period,
    output logic       o_vblank_fall,
    output logic       o_step_due
);

    logic       r_vblank;
    logic       r_vblank_d;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_period;
    logic       w_frame_tick;
    logic       w_last;

    assign w_frame_tick  = r_vblank & ~r_vblank_d;
    assign o_vblank_fall = ~r_vblank & r_vblank_d;
    assign w_last        = (r_frame_cnt == (r_period - 8'd1));
    assign o_step_due    = w_frame_tick & w_last;

    // The period only changes at a wrap so a running count never overshoots it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vblank    <= 1'b0;
            r_vblank_d  <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_period    <= RESET_PERIOD;
        end else begin
            r_vblank   <= (i_frame_y >= 10'(V_ACTIVE));
            r_vblank_d <= r_vblank;
            if (w_frame_tick) begin
                if (w_last) begin
                    r_frame_cnt <= 8'd0;
                    r_period    <= i_period;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/step_scheduler.sv
// Issues game-logic steps at vblank start, arbitrates entity memory and
// latches the filtered joystick direction. Optional speed-up: SNAKE_SPEEDUP_EN.
module step_scheduler
    import step_scheduler_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned MIN_FRAMES      = 2,
    parameter int unsigned V_ACTIVE        = V_ACTIVE_DEF,
    parameter int unsigned TIMEOUT_CYC     = 4096
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_frame_y,
    input  logic [1:0] i_dir_in,
    input  logic       i_pause,
    input  logic       i_game_over,
    input  logic       i_speed_up,
    input  logic       i_step_done,
    output logic       o_step_req,
    output logic [1:0] o_step_dir,
    output logic       o_mem_sel,
    output logic       o_render_stall,
    output logic       o_step_abort,
    output logic       o_overrun,
    output state_t     o_state
);

    localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] PERIOD_INIT  = 8'(FRAMES_PER_STEP);
    localparam logic [7:0] PERIOD_MIN   = 8'(MIN_FRAMES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mem_sel;
    logic               w_mem_sel_nxt;
    logic [TMO_W-1:0]   r_tmo;
    logic [1:0]         r_step_dir;
    logic [1:0]         r_pending_dir;
    logic               r_overrun;
    logic [7:0]         w_period;
    logic               w_step_due;
    logic               w_vblank_fall;
    logic               w_launch;
    logic               w_tmo_hit;

`ifdef SNAKE_SPEEDUP_EN
    logic [7:0] r_speed;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_speed <= PERIOD_INIT;
        end else if (i_speed_up && (r_speed > PERIOD_MIN)) begin
            r_speed <= r_speed - 8'd1;
        end
    end

    assign w_period = r_speed;
`else
    logic w_unused_speed;

    assign w_unused_speed = i_speed_up ^ PERIOD_MIN[0];
    assign w_period       = PERIOD_INIT;
`endif

    frame_tick_gen #(
        .V_ACTIVE    (V_ACTIVE),
        .RESET_PERIOD(PERIOD_INIT)
    ) u_frame_tick_gen (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_frame_y    (i_frame_y),
        .i_period     (w_period),
        .o_vblank_fall(w_vblank_fall),
        .o_step_due   (w_step_due)
    );

    assign w_launch  = w_step_due & ~i_pause & ~i_game_over;
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_mem_sel <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_sel <= w_mem_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_launch) w_state_nxt = ST_REQ;
            ST_REQ:       w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (i_step_done)    w_state_nxt = ST_RELEASE;
                else if (w_tmo_hit) w_state_nxt = ST_IDLE;
            end
            ST_RELEASE:   w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // mem_sel is registered: it follows the owner the FSM hands over at each edge,
    // so the engine keeps the memory through the RELEASE cycle's edge.
    always_comb begin
        o_step_req    = 1'b0;
        o_step_abort  = 1'b0;
        w_mem_sel_nxt = 1'b0;
        case (r_state)
            ST_IDLE:      w_mem_sel_nxt = w_launch;
            ST_REQ: begin
                o_step_req    = 1'b1;
                w_mem_sel_nxt = 1'b1;
            end
            ST_WAIT_DONE: begin
                o_step_abort  = w_tmo_hit & ~i_step_done;
                w_mem_sel_nxt = i_step_done | ~w_tmo_hit;
            end
            default:      w_mem_sel_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tmo         <= '0;
            r_step_dir    <= DIR_RIGHT;
            r_pending_dir <= DIR_RIGHT;
            r_overrun     <= 1'b0;
        end else begin
            if (!is_reversal(i_dir_in, r_step_dir)) begin
                r_pending_dir <= i_dir_in;
            end
            if ((r_state == ST_IDLE) && w_launch) begin
                r_step_dir <= r_pending_dir;
            end
            if (r_state == ST_REQ) begin
                r_tmo <= '0;
            end else if (r_state == ST_WAIT_DONE) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (o_step_abort || (w_step_due && (r_state != ST_IDLE)) ||
                ((r_state == ST_WAIT_DONE) && w_vblank_fall)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_mem_sel      = r_mem_sel;
    assign o_render_stall = r_mem_sel & (i_frame_y < 10'(V_ACTIVE));
    assign o_step_dir     = r_step_dir;
    assign o_overrun      = r_overrun;
    assign o_state        = r_state;

endmodule
